// File: rtl/l2c_mport_arb_pkg.sv
// Shared widths, mode codes and FSM state type for the L2C array-port arbiter.
package l2c_mport_arb_pkg;

  localparam int L2C_WAY_NUM = 2;
  localparam int L2C_TAG_W   = 12;
  localparam int L2C_INDEX_W = 6;
  localparam int CORE_DATA_W = 32;

  localparam int L2C_ARB_RR    = 0;
  localparam int L2C_ARB_FIXED = 1;

  typedef enum logic {
    L2C_ARB_IDLE = 1'b0,
    L2C_ARB_BUSY = 1'b1
  } l2c_arb_state_e;

  function automatic int l2c_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/l2c_mport_arb_if.sv
// Client-side and array-side buses of the L2C array-port arbiter, bundled as one interface.
interface l2c_mport_arb_if
  import l2c_mport_arb_pkg::*;
#(
  parameter int CH_NUM  = 2,
  parameter int WAY_NUM = L2C_WAY_NUM,
  parameter int TAG_W   = L2C_TAG_W,
  parameter int INDEX_W = L2C_INDEX_W,
  parameter int DATA_W  = CORE_DATA_W
);

  localparam int TAG_FW  = TAG_W * WAY_NUM;
  localparam int DATA_FW = DATA_W * WAY_NUM;

  logic [CH_NUM-1:0]         ch_rw_req;
  logic [INDEX_W*CH_NUM-1:0] ch_rw_index;
  logic [WAY_NUM*CH_NUM-1:0] ch_wr_en;
  logic [TAG_FW*CH_NUM-1:0]  ch_wr_tag;
  logic [WAY_NUM*CH_NUM-1:0] ch_wr_valid;
  logic [WAY_NUM*CH_NUM-1:0] ch_wr_dirty;
  logic [DATA_FW*CH_NUM-1:0] ch_wr_data;

  logic [CH_NUM-1:0]         ch_rw_rdy;
  logic [TAG_FW*CH_NUM-1:0]  ch_rd_tag;
  logic [WAY_NUM*CH_NUM-1:0] ch_rd_valid;
  logic [WAY_NUM*CH_NUM-1:0] ch_rd_dirty;
  logic [DATA_FW*CH_NUM-1:0] ch_rd_data;
  logic [CH_NUM-1:0]         ch_grnt;

  logic                      rw_req;
  logic [INDEX_W-1:0]        rw_index;
  logic [WAY_NUM-1:0]        wr_en_pack;
  logic [TAG_FW-1:0]         wr_tag_pack;
  logic [WAY_NUM-1:0]        wr_valid_pack;
  logic [WAY_NUM-1:0]        wr_dirty_pack;
  logic [DATA_FW-1:0]        wr_data_pack;

  logic                      rw_rdy;
  logic [TAG_FW-1:0]         rd_tag_pack;
  logic [WAY_NUM-1:0]        rd_valid_pack;
  logic [WAY_NUM-1:0]        rd_dirty_pack;
  logic [DATA_FW-1:0]        rd_data_pack;

  modport slave (
    input  ch_rw_req, ch_rw_index, ch_wr_en, ch_wr_tag, ch_wr_valid, ch_wr_dirty, ch_wr_data,
    input  rw_rdy, rd_tag_pack, rd_valid_pack, rd_dirty_pack, rd_data_pack,
    output ch_rw_rdy, ch_rd_tag, ch_rd_valid, ch_rd_dirty, ch_rd_data, ch_grnt,
    output rw_req, rw_index, wr_en_pack, wr_tag_pack, wr_valid_pack, wr_dirty_pack, wr_data_pack
  );

  modport master (
    output ch_rw_req, ch_rw_index, ch_wr_en, ch_wr_tag, ch_wr_valid, ch_wr_dirty, ch_wr_data,
    output rw_rdy, rd_tag_pack, rd_valid_pack, rd_dirty_pack, rd_data_pack,
    input  ch_rw_rdy, ch_rd_tag, ch_rd_valid, ch_rd_dirty, ch_rd_data, ch_grnt,
    input  rw_req, rw_index, wr_en_pack, wr_tag_pack, wr_valid_pack, wr_dirty_pack, wr_data_pack
  );

endinterface

// File: rtl/l2c_mport_arb_pick.sv
// Combinational rotate-priority picker: round-robin after i_ptr, or fixed with ch0 highest.
module l2c_mport_arb_pick
  import l2c_mport_arb_pkg::*;
#(
  parameter int CH_NUM = 2,
  parameter int IDX_W  = l2c_idx_w(CH_NUM)
) (
  input  logic [CH_NUM-1:0] i_req,
  input  logic [IDX_W-1:0]  i_ptr,
  input  logic              i_mode,
  output logic              o_vld,
  output logic [CH_NUM-1:0] o_onehot,
  output logic [IDX_W-1:0]  o_idx
);

  int w_cand;

  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    o_vld    = 1'b0;
    o_onehot = '0;
    o_idx    = '0;
    w_cand   = 0;
    for (int k = CH_NUM; k >= 1; k--) begin
      w_cand = i_mode ? (k - 1) : ((int'(i_ptr) + k) % CH_NUM);
      if (i_req[w_cand]) begin
        o_vld    = 1'b1;
        o_onehot = CH_NUM'(1) << w_cand;
        o_idx    = IDX_W'(w_cand);
      end
    end
  end

endmodule

// File: rtl/l2c_mport_arb.sv
// N-channel arbiter/mux in front of the single rw port of the L2C tag/data arrays.
module l2c_mport_arb
  import l2c_mport_arb_pkg::*;
#(
  parameter int CH_NUM  = 2,
  parameter int WAY_NUM = L2C_WAY_NUM,
  parameter int TAG_W   = L2C_TAG_W,
  parameter int INDEX_W = L2C_INDEX_W,
  parameter int DATA_W  = CORE_DATA_W,
  parameter int MODE    = L2C_ARB_RR
) (
  input  logic           clk,
  input  logic           rst_n,
  l2c_mport_arb_if.slave io_arb
);

  localparam int IDX_W   = l2c_idx_w(CH_NUM);
  localparam int TAG_FW  = TAG_W * WAY_NUM;
  localparam int DATA_FW = DATA_W * WAY_NUM;

  l2c_arb_state_e    r_state, w_next_state;
  logic [IDX_W-1:0]  r_owner, w_next_owner;
  logic [IDX_W-1:0]  r_rr_ptr, w_next_ptr;

  logic              w_pick_vld;
  logic [CH_NUM-1:0] w_pick_oh;
  logic [IDX_W-1:0]  w_pick_idx;

  logic              w_owner_req;
  logic              w_sel_vld;
  logic [IDX_W-1:0]  w_sel_idx;
  logic [CH_NUM-1:0] w_sel_oh;
  logic              w_en;
  logic [CH_NUM-1:0] w_grnt;
  int                w_sel;

  l2c_mport_arb_pick #(
    .CH_NUM (CH_NUM),
    .IDX_W  (IDX_W)
  ) u_pick (
    .i_req    (io_arb.ch_rw_req),
    .i_ptr    (r_rr_ptr),
    .i_mode   (MODE == L2C_ARB_FIXED),
    .o_vld    (w_pick_vld),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx)
  );

  assign w_owner_req = io_arb.ch_rw_req[r_owner];

  // Once BUSY the mux is pinned to the owner; dropping its req aborts the access.
  always_comb begin
    w_sel_vld = w_pick_vld;
    w_sel_idx = w_pick_idx;
    w_sel_oh  = w_pick_oh;
    if (r_state == L2C_ARB_BUSY) begin
      w_sel_vld = w_owner_req;
      w_sel_idx = r_owner;
      w_sel_oh  = CH_NUM'(1) << r_owner;
    end
  end

  // Gating with rst_n keeps every output quiet while reset is held, even mid-access.
  assign w_en   = rst_n & w_sel_vld;
  assign w_grnt = w_en ? w_sel_oh : '0;
  assign w_sel  = int'(w_sel_idx);

  assign io_arb.ch_grnt   = w_grnt;
  assign io_arb.ch_rw_rdy = io_arb.rw_rdy ? w_grnt : '0;

  always_comb begin
    io_arb.rw_req        = 1'b0;
    io_arb.rw_index      = '0;
    io_arb.wr_en_pack    = '0;
    io_arb.wr_tag_pack   = '0;
    io_arb.wr_valid_pack = '0;
    io_arb.wr_dirty_pack = '0;
    io_arb.wr_data_pack  = '0;
    if (w_en) begin
      io_arb.rw_req        = 1'b1;
      io_arb.rw_index      = io_arb.ch_rw_index[w_sel*INDEX_W +: INDEX_W];
      io_arb.wr_en_pack    = io_arb.ch_wr_en[w_sel*WAY_NUM +: WAY_NUM];
      io_arb.wr_tag_pack   = io_arb.ch_wr_tag[w_sel*TAG_FW +: TAG_FW];
      io_arb.wr_valid_pack = io_arb.ch_wr_valid[w_sel*WAY_NUM +: WAY_NUM];
      io_arb.wr_dirty_pack = io_arb.ch_wr_dirty[w_sel*WAY_NUM +: WAY_NUM];
      io_arb.wr_data_pack  = io_arb.ch_wr_data[w_sel*DATA_FW +: DATA_FW];
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_rd
    assign io_arb.ch_rd_tag[g*TAG_FW +: TAG_FW]    = w_grnt[g] ? io_arb.rd_tag_pack   : '0;
    assign io_arb.ch_rd_valid[g*WAY_NUM +: WAY_NUM] = w_grnt[g] ? io_arb.rd_valid_pack : '0;
    assign io_arb.ch_rd_dirty[g*WAY_NUM +: WAY_NUM] = w_grnt[g] ? io_arb.rd_dirty_pack : '0;
    assign io_arb.ch_rd_data[g*DATA_FW +: DATA_FW] = w_grnt[g] ? io_arb.rd_data_pack  : '0;
  end

  // A same-cycle completion in IDLE also advances the round-robin pointer.
  always_comb begin
    w_next_state = r_state;
    w_next_owner = r_owner;
    w_next_ptr   = r_rr_ptr;
    case (r_state)
      L2C_ARB_IDLE: begin
        if (w_pick_vld) begin
          if (io_arb.rw_rdy) begin
            w_next_ptr = w_pick_idx;
          end else begin
            w_next_state = L2C_ARB_BUSY;
            w_next_owner = w_pick_idx;
          end
        end
      end
      L2C_ARB_BUSY: begin
        if (!w_owner_req || io_arb.rw_rdy) begin
          w_next_state = L2C_ARB_IDLE;
          w_next_ptr   = r_owner;
        end
      end
      default: w_next_state = L2C_ARB_IDLE;
    endcase
    if (MODE == L2C_ARB_FIXED) begin
      w_next_ptr = r_rr_ptr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= L2C_ARB_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= IDX_W'(CH_NUM - 1);
    end else begin
      r_state  <= w_next_state;
      r_owner  <= w_next_owner;
      r_rr_ptr <= w_next_ptr;
    end
  end

endmodule

// File: tb/tb_l2c_mport_arb.sv
// Scoreboard bench for l2c_mport_arb: a round-robin and a fixed-priority instance, 4 channels each.
module tb_l2c_mport_arb;
  import l2c_mport_arb_pkg::*;

  localparam int CH  = 4;
  localparam int WN  = L2C_WAY_NUM;
  localparam int TW  = L2C_TAG_W;
  localparam int IW  = L2C_INDEX_W;
  localparam int DW  = CORE_DATA_W;
  localparam int TFW = TW * WN;
  localparam int DFW = DW * WN;

  typedef struct {
    int              ch;
    logic [IW-1:0]   idx;
    logic [DFW-1:0]  rd;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  exp_t q_rr[$];
  exp_t q_fx[$];
  exp_t mon_rr_e;
  exp_t mon_fx_e;
  logic [CH*DFW-1:0] mon_rr_full;
  logic [CH*DFW-1:0] mon_fx_full;

  l2c_mport_arb_if #(.CH_NUM(CH), .WAY_NUM(WN), .TAG_W(TW), .INDEX_W(IW), .DATA_W(DW)) arr_rr ();
  l2c_mport_arb_if #(.CH_NUM(CH), .WAY_NUM(WN), .TAG_W(TW), .INDEX_W(IW), .DATA_W(DW)) arr_fx ();

  l2c_mport_arb #(
    .CH_NUM(CH), .WAY_NUM(WN), .TAG_W(TW), .INDEX_W(IW), .DATA_W(DW), .MODE(L2C_ARB_RR)
  ) u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_arb (arr_rr)
  );

  l2c_mport_arb #(
    .CH_NUM(CH), .WAY_NUM(WN), .TAG_W(TW), .INDEX_W(IW), .DATA_W(DW), .MODE(L2C_ARB_FIXED)
  ) u_fx (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_arb (arr_fx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [IW-1:0] idx_of(input int c);
    return IW'(c * 5 + 3);
  endfunction

  function automatic logic [TFW-1:0] tag_of(input int c);
    logic [TFW-1:0] r;
    for (int w = 0; w < WN; w++) r[w*TW +: TW] = TW'(32'hA00 + c * 16 + w);
    return r;
  endfunction

  function automatic logic [DFW-1:0] data_of(input int c);
    logic [DFW-1:0] r;
    for (int w = 0; w < WN; w++) r[w*DW +: DW] = DW'(32'hD000_0000 + c * 256 + w);
    return r;
  endfunction

  task automatic init_fields();
    for (int c = 0; c < CH; c++) begin
      arr_rr.ch_rw_index[c*IW +: IW]  = idx_of(c);
      arr_rr.ch_wr_tag[c*TFW +: TFW]  = tag_of(c);
      arr_rr.ch_wr_data[c*DFW +: DFW] = data_of(c);
      arr_rr.ch_wr_en[c*WN +: WN]     = WN'(c + 1);
      arr_rr.ch_wr_valid[c*WN +: WN]  = '1;
      arr_rr.ch_wr_dirty[c*WN +: WN]  = WN'(c);
      arr_fx.ch_rw_index[c*IW +: IW]  = idx_of(c);
      arr_fx.ch_wr_tag[c*TFW +: TFW]  = tag_of(c);
      arr_fx.ch_wr_data[c*DFW +: DFW] = data_of(c);
      arr_fx.ch_wr_en[c*WN +: WN]     = WN'(c + 1);
      arr_fx.ch_wr_valid[c*WN +: WN]  = '1;
      arr_fx.ch_wr_dirty[c*WN +: WN]  = WN'(c);
    end
    arr_rr.rd_valid_pack = '1;
    arr_rr.rd_dirty_pack = '0;
    arr_fx.rd_valid_pack = '1;
    arr_fx.rd_dirty_pack = '0;
  endtask

  task automatic drive_rr(input logic [CH-1:0] req, input logic rdy, input logic [DFW-1:0] rd);
    @(posedge clk);
    #1;
    arr_rr.ch_rw_req    = req;
    arr_rr.rw_rdy       = rdy;
    arr_rr.rd_data_pack = rd;
    arr_rr.rd_tag_pack  = TFW'(rd);
  endtask

  task automatic drive_fx(input logic [CH-1:0] req, input logic rdy, input logic [DFW-1:0] rd);
    @(posedge clk);
    #1;
    arr_fx.ch_rw_req    = req;
    arr_fx.rw_rdy       = rdy;
    arr_fx.rd_data_pack = rd;
    arr_fx.rd_tag_pack  = TFW'(rd);
  endtask

  // Completion monitors: every ch_rw_rdy strobe must match the oldest expected access.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && arr_rr.ch_rw_rdy !== '0) begin
      n_checks++;
      if (q_rr.size() == 0) begin
        n_errors++;
        $display("[TB] FAIL rr_unexpected_rdy got=%b want=0000", arr_rr.ch_rw_rdy);
      end else begin
        mon_rr_e = q_rr.pop_front();
        mon_rr_full = '0;
        mon_rr_full[mon_rr_e.ch*DFW +: DFW] = mon_rr_e.rd;
        if (arr_rr.ch_rw_rdy !== CH'(1 << mon_rr_e.ch)) begin
          n_errors++;
          $display("[TB] FAIL rr_rdy_owner got=%b want=%b", arr_rr.ch_rw_rdy, CH'(1 << mon_rr_e.ch));
        end
        n_checks++;
        if (arr_rr.rw_index !== mon_rr_e.idx) begin
          n_errors++;
          $display("[TB] FAIL rr_rdy_index got=%h want=%h", arr_rr.rw_index, mon_rr_e.idx);
        end
        n_checks++;
        if (arr_rr.ch_rd_data !== mon_rr_full) begin
          n_errors++;
          $display("[TB] FAIL rr_rd_route got=%h want=%h", arr_rr.ch_rd_data, mon_rr_full);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && arr_fx.ch_rw_rdy !== '0) begin
      n_checks++;
      if (q_fx.size() == 0) begin
        n_errors++;
        $display("[TB] FAIL fx_unexpected_rdy got=%b want=0000", arr_fx.ch_rw_rdy);
      end else begin
        mon_fx_e = q_fx.pop_front();
        mon_fx_full = '0;
        mon_fx_full[mon_fx_e.ch*DFW +: DFW] = mon_fx_e.rd;
        if (arr_fx.ch_rw_rdy !== CH'(1 << mon_fx_e.ch)) begin
          n_errors++;
          $display("[TB] FAIL fx_rdy_owner got=%b want=%b", arr_fx.ch_rw_rdy, CH'(1 << mon_fx_e.ch));
        end
        n_checks++;
        if (arr_fx.rw_index !== mon_fx_e.idx) begin
          n_errors++;
          $display("[TB] FAIL fx_rdy_index got=%h want=%h", arr_fx.rw_index, mon_fx_e.idx);
        end
        n_checks++;
        if (arr_fx.ch_rd_data !== mon_fx_full) begin
          n_errors++;
          $display("[TB] FAIL fx_rd_route got=%h want=%h", arr_fx.ch_rd_data, mon_fx_full);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    arr_rr.ch_rw_req = '1; arr_rr.rw_rdy = 1'b1; arr_rr.rd_data_pack = '1; arr_rr.rd_tag_pack = '1;
    arr_fx.ch_rw_req = '1; arr_fx.rw_rdy = 1'b1; arr_fx.rd_data_pack = '1; arr_fx.rd_tag_pack = '1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (arr_rr.rw_req !== 1'b0) begin
      n_errors++; $display("[TB] FAIL reset_rw_req got=%b want=0", arr_rr.rw_req);
    end
    n_checks++;
    if (arr_rr.ch_grnt !== '0) begin
      n_errors++; $display("[TB] FAIL reset_grnt got=%b want=0000", arr_rr.ch_grnt);
    end
    n_checks++;
    if (arr_rr.ch_rw_rdy !== '0) begin
      n_errors++; $display("[TB] FAIL reset_rdy got=%b want=0000", arr_rr.ch_rw_rdy);
    end
    n_checks++;
    if (arr_rr.wr_data_pack !== '0 || arr_rr.ch_rd_data !== '0) begin
      n_errors++; $display("[TB] FAIL reset_data got=%h/%h want=0", arr_rr.wr_data_pack, arr_rr.ch_rd_data);
    end
    n_checks++;
    if (arr_fx.ch_grnt !== '0 || arr_fx.rw_req !== 1'b0) begin
      n_errors++; $display("[TB] FAIL reset_fx_grnt got=%b/%b want=0", arr_fx.ch_grnt, arr_fx.rw_req);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    arr_rr.ch_rw_req = '0; arr_rr.rw_rdy = 1'b0; arr_rr.rd_data_pack = '0; arr_rr.rd_tag_pack = '0;
    arr_fx.ch_rw_req = '0; arr_fx.rw_rdy = 1'b0; arr_fx.rd_data_pack = '0; arr_fx.rd_tag_pack = '0;
    @(negedge clk);
    n_checks++;
    if (arr_rr.rw_req !== 1'b0 || arr_rr.rw_index !== '0 || arr_rr.wr_tag_pack !== '0) begin
      n_errors++;
      $display("[TB] FAIL idle_outputs got=%b/%h/%h want=0", arr_rr.rw_req, arr_rr.rw_index, arr_rr.wr_tag_pack);
    end
  endtask

  task automatic test_rr_alternate();
    exp_t e;
    logic [DFW-1:0] rd;
    for (int i = 0; i < 6; i++) begin
      rd = {$urandom(), $urandom()};
      e.ch = i % 2; e.idx = idx_of(i % 2); e.rd = rd;
      q_rr.push_back(e);
      drive_rr(4'b0011, 1'b1, rd);
      @(negedge clk);
      n_checks++;
      if (arr_rr.ch_grnt !== CH'(1 << (i % 2))) begin
        n_errors++; $display("[TB] FAIL rr_alt_grnt got=%b want=%b", arr_rr.ch_grnt, CH'(1 << (i % 2)));
      end
      n_checks++;
      if (arr_rr.wr_data_pack !== data_of(i % 2)) begin
        n_errors++; $display("[TB] FAIL rr_alt_wdata got=%h want=%h", arr_rr.wr_data_pack, data_of(i % 2));
      end
    end
    drive_rr('0, 1'b0, '0);
  endtask

  task automatic test_fixed_priority();
    exp_t e;
    logic [DFW-1:0] rd;
    for (int i = 0; i < 5; i++) begin
      rd = {$urandom(), $urandom()};
      e.ch = 1; e.idx = idx_of(1); e.rd = rd;
      q_fx.push_back(e);
      drive_fx(4'b1010, 1'b1, rd);
      @(negedge clk);
      n_checks++;
      if (arr_fx.ch_grnt !== 4'b0010 || arr_fx.wr_tag_pack !== tag_of(1)) begin
        n_errors++;
        $display("[TB] FAIL fx_grnt got=%b/%h want=0010/%h", arr_fx.ch_grnt, arr_fx.wr_tag_pack, tag_of(1));
      end
    end
    rd = {$urandom(), $urandom()};
    e.ch = 3; e.idx = idx_of(3); e.rd = rd;
    q_fx.push_back(e);
    drive_fx(4'b1000, 1'b1, rd);
    @(negedge clk);
    n_checks++;
    if (arr_fx.ch_grnt !== 4'b1000) begin
      n_errors++; $display("[TB] FAIL fx_only_ch3 got=%b want=1000", arr_fx.ch_grnt);
    end
    drive_fx('0, 1'b0, '0);
  endtask

  task automatic test_busy_lock();
    exp_t e;
    logic [DFW-1:0] rd;
    drive_rr(4'b0100, 1'b0, '0);
    @(negedge clk);
    n_checks++;
    if (arr_rr.ch_grnt !== 4'b0100 || arr_rr.rw_req !== 1'b1) begin
      n_errors++; $display("[TB] FAIL busy_first got=%b/%b want=0100/1", arr_rr.ch_grnt, arr_rr.rw_req);
    end
    for (int i = 0; i < 2; i++) begin
      drive_rr(4'b0101, 1'b0, '0);
      @(negedge clk);
      n_checks++;
      if (arr_rr.ch_grnt !== 4'b0100 || arr_rr.wr_data_pack !== data_of(2) || arr_rr.rw_index !== idx_of(2)) begin
        n_errors++;
        $display("[TB] FAIL busy_locked got=%b/%h want=0100/%h", arr_rr.ch_grnt, arr_rr.wr_data_pack, data_of(2));
      end
    end
    rd = {$urandom(), $urandom()};
    e.ch = 2; e.idx = idx_of(2); e.rd = rd;
    q_rr.push_back(e);
    drive_rr(4'b0101, 1'b1, rd);
    @(negedge clk);
    n_checks++;
    if (arr_rr.ch_grnt !== 4'b0100) begin
      n_errors++; $display("[TB] FAIL busy_rdy_grnt got=%b want=0100", arr_rr.ch_grnt);
    end
    rd = {$urandom(), $urandom()};
    e.ch = 0; e.idx = idx_of(0); e.rd = rd;
    q_rr.push_back(e);
    drive_rr(4'b0001, 1'b1, rd);
    @(negedge clk);
    n_checks++;
    if (arr_rr.ch_grnt !== 4'b0001) begin
      n_errors++; $display("[TB] FAIL busy_next_grnt got=%b want=0001", arr_rr.ch_grnt);
    end
    drive_rr('0, 1'b0, '0);
  endtask

  task automatic test_abort();
    exp_t e;
    logic [DFW-1:0] rd;
    drive_rr(4'b0100, 1'b0, '0);
    @(negedge clk);
    n_checks++;
    if (arr_rr.ch_grnt !== 4'b0100) begin
      n_errors++; $display("[TB] FAIL abort_grnt got=%b want=0100", arr_rr.ch_grnt);
    end
    drive_rr(4'b0000, 1'b1, '1);
    @(negedge clk);
    n_checks++;
    if (arr_rr.rw_req !== 1'b0 || arr_rr.ch_grnt !== '0 || arr_rr.ch_rw_rdy !== '0) begin
      n_errors++;
      $display("[TB] FAIL abort_quiet got=%b/%b/%b want=0/0000/0000", arr_rr.rw_req, arr_rr.ch_grnt, arr_rr.ch_rw_rdy);
    end
    rd = {$urandom(), $urandom()};
    e.ch = 3; e.idx = idx_of(3); e.rd = rd;
    q_rr.push_back(e);
    drive_rr(4'b1010, 1'b1, rd);
    @(negedge clk);
    n_checks++;
    if (arr_rr.ch_grnt !== 4'b1000) begin
      n_errors++; $display("[TB] FAIL abort_ptr got=%b want=1000", arr_rr.ch_grnt);
    end
    drive_rr('0, 1'b0, '0);
  endtask

  task automatic test_reset_mid_busy();
    exp_t e;
    logic [DFW-1:0] rd;
    drive_rr(4'b0010, 1'b0, '0);
    drive_rr(4'b0010, 1'b0, '0);
    @(negedge clk);
    n_checks++;
    if (arr_rr.ch_grnt !== 4'b0010) begin
      n_errors++; $display("[TB] FAIL midrst_busy got=%b want=0010", arr_rr.ch_grnt);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (arr_rr.rw_req !== 1'b0 || arr_rr.ch_grnt !== '0 || arr_rr.wr_data_pack !== '0 || arr_rr.rw_index !== '0) begin
      n_errors++;
      $display("[TB] FAIL midrst_async got=%b/%b/%h want=0", arr_rr.rw_req, arr_rr.ch_grnt, arr_rr.wr_data_pack);
    end
    rd = {$urandom(), $urandom()};
    e.ch = 0; e.idx = idx_of(0); e.rd = rd;
    q_rr.push_back(e);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    arr_rr.ch_rw_req = 4'b0011; arr_rr.rw_rdy = 1'b1; arr_rr.rd_data_pack = rd; arr_rr.rd_tag_pack = TFW'(rd);
    @(negedge clk);
    n_checks++;
    if (arr_rr.ch_grnt !== 4'b0001) begin
      n_errors++; $display("[TB] FAIL midrst_first got=%b want=0001", arr_rr.ch_grnt);
    end
    drive_rr('0, 1'b0, '0);
  endtask

  task automatic test_read_return();
    exp_t e;
    logic [DFW-1:0] rd;
    logic [CH*DFW-1:0] others;
    rd = '0;
    for (int b = 0; b < DFW / 8; b++) rd[b*8 +: 8] = 8'hA5;
    e.ch = 1; e.idx = idx_of(1); e.rd = rd;
    q_rr.push_back(e);
    drive_rr(4'b0010, 1'b1, rd);
    @(negedge clk);
    n_checks++;
    if (arr_rr.ch_rd_data[DFW +: DFW] !== rd) begin
      n_errors++; $display("[TB] FAIL rdret_owner got=%h want=%h", arr_rr.ch_rd_data[DFW +: DFW], rd);
    end
    others = arr_rr.ch_rd_data;
    others[DFW +: DFW] = '0;
    n_checks++;
    if (others !== '0) begin
      n_errors++; $display("[TB] FAIL rdret_others got=%h want=0", others);
    end
    n_checks++;
    if (arr_rr.ch_rd_tag[TFW +: TFW] !== TFW'(rd) || arr_rr.ch_rw_rdy !== 4'b0010) begin
      n_errors++;
      $display("[TB] FAIL rdret_tag got=%h/%b want=%h/0010", arr_rr.ch_rd_tag[TFW +: TFW], arr_rr.ch_rw_rdy, TFW'(rd));
    end
    drive_rr('0, 1'b0, '0);
  endtask

  task automatic test_drain();
    repeat (2) @(negedge clk);
    n_checks++;
    if (q_rr.size() != 0 || q_fx.size() != 0) begin
      n_errors++; $display("[TB] FAIL drain_pending got=%0d/%0d want=0/0", q_rr.size(), q_fx.size());
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    init_fields();
    test_reset();
    test_rr_alternate();
    test_fixed_priority();
    test_busy_lock();
    test_abort();
    test_reset_mid_busy();
    test_read_return();
    test_drain();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
